// File: rtl/gray_wavefront_ctrl_pkg.sv
// gray_wavefront_ctrl_pkg: shared FSM state type, error codes and timeout default
package gray_wavefront_ctrl_pkg;
    typedef enum logic [2:0] {S_IDLE, S_NULL, S_DATA, S_DONE, S_ERR} state_t;
    localparam logic [1:0] E_NONE = 2'b00;
    localparam logic [1:0] E_NULL = 2'b01;
    localparam logic [1:0] E_DATA = 2'b10;
    localparam logic [1:0] E_ILL  = 2'b11;
    localparam int TIMEOUT_DEF = 15;
endpackage

// File: rtl/dr_completion_detect.sv
// dr_completion_detect: 4-pair dual-rail spacer/data/illegal detection
// t/f: true/false rails; all_null: every rail low; all_data: every pair one-hot; illegal: any pair with both rails high
module dr_completion_detect (
    input  logic [3:0] t,
    input  logic [3:0] f,
    output logic       all_null,
    output logic       all_data,
    output logic       illegal
);
    assign all_null = ~|(t | f);
    assign all_data = &(t ^ f);
    assign illegal  = |(t & f);
endmodule

// File: rtl/gray_wavefront_ctrl.sv
// gray_wavefront_ctrl: two-requester arbiter driving a dual-rail Gray encoder through spacer/data wavefronts
// req/data/ack per requester; enc_in_* drive the encoder, enc_out_* come back; result/result_valid carry the Gray word; err/err_code/err_clr report faults
module gray_wavefront_ctrl
    import gray_wavefront_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] data0,
    input  logic [3:0] data1,
    output logic       ack0,
    output logic       ack1,
    output logic [3:0] result,
    output logic       result_valid,
    output logic [3:0] enc_in_t,
    output logic [3:0] enc_in_f,
    input  logic [3:0] enc_out_t,
    input  logic [3:0] enc_out_f,
    input  logic       err_clr,
    output logic       err,
    output logic [1:0] err_code
);
    state_t     state, nxt;
    logic [1:0] code_n;
    logic [7:0] cnt;
    logic [3:0] lat;
    logic       gnt, last, pick;
    logic       all_null, all_data, illegal;

    dr_completion_detect u_cd (
        .t        (enc_out_t),
        .f        (enc_out_f),
        .all_null (all_null),
        .all_data (all_data),
        .illegal  (illegal)
    );

    // ties go to whoever did not win last time
    assign pick = (req0 & req1) ? ~last : req1;

    always_comb begin
        nxt    = state;
        code_n = err_code;
        case (state)
            S_IDLE: nxt = (req0 | req1) ? S_NULL : S_IDLE;
            S_NULL: begin
                if (all_null) nxt = S_DATA;
                else if (cnt == 8'(TIMEOUT)) begin
                    nxt    = S_ERR;
                    code_n = E_NULL;
                end
            end
            S_DATA: begin
                if (all_data) nxt = S_DONE;
                else if (cnt == 8'(TIMEOUT)) begin
                    nxt    = S_ERR;
                    code_n = E_DATA;
                end
            end
            S_DONE: nxt = S_IDLE;
            S_ERR: begin
                if (err_clr) begin
                    nxt    = S_IDLE;
                    code_n = E_NONE;
                end
            end
            default: nxt = S_IDLE;
        endcase
        if (illegal && state != S_ERR) begin
            nxt    = S_ERR;
            code_n = E_ILL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            err_code <= E_NONE;
            cnt      <= '0;
            lat      <= '0;
            gnt      <= 1'b0;
            last     <= 1'b1;
            result   <= '0;
            enc_in_t <= '0;
            enc_in_f <= '0;
        end else begin
            state    <= nxt;
            err_code <= code_n;
            // any state change clears the wait counter, so it restarts on entry to NULL and DATA
            cnt      <= (nxt != state) ? '0 : cnt + 8'(state == S_NULL || state == S_DATA);
            if (state == S_IDLE && nxt == S_NULL) begin
                gnt  <= pick;
                last <= pick;
                lat  <= pick ? data1 : data0;
            end
            // rails carry data only while in DATA, spacer otherwise
            enc_in_t <= (nxt == S_DATA) ? ((state == S_NULL) ? lat : enc_in_t) : '0;
            enc_in_f <= (nxt == S_DATA) ? ((state == S_NULL) ? ~lat : enc_in_f) : '0;
            if (state == S_DATA && nxt == S_DONE) result <= enc_out_t;
        end
    end

    assign ack0         = (state == S_DONE) & ~gnt;
    assign ack1         = (state == S_DONE) & gnt;
    assign result_valid = (state == S_DONE);
    assign err          = (state == S_ERR);
endmodule

// File: doc/gray_wavefront_ctrl.md
GRAY_WAVEFRONT_CTRL -- requirements
Module: gray_wavefront_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 15, max cycles spent waiting in NULL or DATA before error (range 2..255).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0 / req1  input  1 each  requester 0/1 conversion request, level.
REQ-005 data0 / data1  input  4 each  requester binary word, bit3 = A ... bit0 = D.
REQ-006 ack0 / ack1  output  1 each  one-cycle completion pulse to granted requester.
REQ-007 result  output  4  captured Gray word, bit3 = out3 ... bit0 = out0.
REQ-008 result_valid  output  1  high in the same cycle as ack0/ack1.
REQ-009 enc_in_t / enc_in_f  output  4 each  registered dual-rail drive into the Gray encoder.
REQ-010 enc_out_t / enc_out_f  input  4 each  dual-rail encoder outputs.
REQ-011 err_clr  input  1  clears sticky error.
REQ-012 err  output  1  sticky error flag; err_code  output  2  01 null timeout, 10 data timeout, 11 illegal code.

Function
REQ-013 FSM states: IDLE, NULL, DATA, DONE, ERR.
REQ-014 enc_in_t/enc_in_f SHALL be all-zero (spacer) in every state except DATA.
REQ-015 IDLE: if req0 or req1, grant one requester, latch its data, go to NULL; otherwise stay.
REQ-016 Arbitration: round-robin on simultaneous requests; last-grant resets to requester 1, so requester 0 wins the first tie.
REQ-017 NULL: when all 8 enc_out rails are 0, load enc_in_t = latched data and enc_in_f = ~latched data, then go to DATA.
REQ-018 DATA: when every output pair is exactly one-hot, register result = enc_out_t and go to DONE.
REQ-019 DONE: for exactly one cycle, drive the granted ackN = 1 and result_valid = 1, then go to IDLE.
REQ-020 result SHALL hold its value until the next DONE.
REQ-021 Latency: with a zero-delay encoder, a request sampled at edge N SHALL produce ack high between edges N+2 and N+3.
REQ-022 Data changes or req deassertion after grant SHALL be ignored until the next IDLE.
REQ-023 Timeout: a 8-bit wait counter clears on entry to NULL and on entry to DATA and increments each cycle spent there.
REQ-024 When the wait counter reaches TIMEOUT, the next state SHALL be ERR with code 01 (from NULL) or 10 (from DATA).
REQ-025 In any state, any pair with both rails high SHALL cause entry to ERR with code 11 at the next edge; this takes priority over timeout.
REQ-026 ERR: err = 1 and err_code holds its value, no ack is issued, and the granted transaction is dropped; on err_clr go to IDLE with err = 0 and err_code = 00.
REQ-027 Requests arriving in NULL, DATA, DONE or ERR SHALL wait; they are only sampled in IDLE.

Reset
REQ-028 rst SHALL immediately force: state IDLE, enc_in rails 0, ack0/ack1/result_valid 0, result 0000, err 0, err_code 00, counter 0, last-grant = 1.
REQ-029 rst asserted mid-transaction SHALL abort the transaction without an ack.

Structure
REQ-030 A shared package SHALL hold the state enum, the err_code constants and the TIMEOUT default.
REQ-031 Completion detection SHALL be one sub-module, dr_completion_detect, with 4-pair dual-rail input and outputs all_null, all_data, illegal.

Verification
REQ-032 req0 = 1 with data0 = 1011, ideal encoder model -> ack0 at N+2 with result = 1110 and result_valid = 1; enc_in returns to all-zero.
REQ-033 req0 and req1 asserted together, data0 = 0100, data1 = 1111, both held -> ack0 with result = 0110, then ack1 with result = 1000.
REQ-034 Encoder model holds out2 at null in DATA, TIMEOUT = 15 -> err = 1 and err_code = 10 after 15 DATA cycles with no ack; err_clr -> IDLE and err = 0.
REQ-035 Encoder model drives out1_t = out1_f = 1 -> next edge: err = 1, err_code = 11.
REQ-036 rst pulsed while in DATA -> enc_in rails 0 and ack 0 immediately; a new req0 afterwards completes normally.
